// File: rtl/johnson_pkg.sv
// johnson_pkg: shared types and Johnson-code helpers (legality, decode, index stepping)
package johnson_pkg;
  localparam int MAX_FF = 16;
  typedef enum logic {HUNT, LOCKED} state_t;
  // Legal iff at most one adjacent-bit transition within the low n bits
  function automatic logic jc_legal(input logic [MAX_FF-1:0] code, input int n);
    int t;
    t = 0;
    for (int i = 0; i < MAX_FF - 1; i++)
      if (i < n - 1 && code[i] != code[i+1]) t++;
    return t <= 1;
  endfunction
  function automatic logic [4:0] jc_to_idx(input logic [MAX_FF-1:0] code, input int n);
    int p;
    p = 0;
    for (int i = 0; i < MAX_FF; i++)
      if (i < n) p += int'(code[i]);
    return (code == '0 || code[n-1]) ? 5'(p) : 5'(2 * n - p);
  endfunction
  function automatic logic [4:0] jc_next_idx(input logic [4:0] idx, input int n);
    return idx == 5'(2 * n - 1) ? 5'd0 : idx + 5'd1;
  endfunction
  function automatic logic [4:0] jc_prev_idx(input logic [4:0] idx, input int n);
    return idx == 5'd0 ? 5'(2 * n - 1) : idx - 5'd1;
  endfunction
endpackage

// File: rtl/johnson_code_decode.sv
// johnson_code_decode: combinational legality check and binary index of a Johnson code
module johnson_code_decode
  import johnson_pkg::*;
#(
  parameter int NUM_FF = 4,
  parameter int IDX_W  = $clog2(2 * NUM_FF)
) (
  input  logic [NUM_FF-1:0] jc_in,
  output logic              legal,
  output logic [IDX_W-1:0]  idx
);
  logic [MAX_FF-1:0] code;
  assign code  = MAX_FF'(jc_in);
  assign legal = jc_legal(code, NUM_FF);
  assign idx   = legal ? IDX_W'(jc_to_idx(code, NUM_FF)) : '0;
endmodule

// File: rtl/johnson_decoder_monitor.sv
// johnson_decoder_monitor: Johnson-bus decoder with HUNT/LOCKED continuity monitor.
// Define JDEC_BIDIR_EN to accept descending sequences and expose the dir output.
module johnson_decoder_monitor
  import johnson_pkg::*;
#(
  parameter int NUM_FF   = 4,
  parameter int IDX_W    = $clog2(2 * NUM_FF),
  parameter int ERR_W    = 8,
  parameter int LOCK_CNT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [NUM_FF-1:0] jc_in,
  output logic [IDX_W-1:0]  idx_out,
  output logic              idx_valid,
  output logic              legal,
  output logic              seq_err,
  output logic              locked,
`ifdef JDEC_BIDIR_EN
  output logic              dir,
`endif
  output logic [ERR_W-1:0]  err_count
);
  state_t state, state_n;
  logic [3:0] run, run_n;
  logic [IDX_W-1:0] prev, dec_idx;
  logic prev_v, prev_v_n, dec_legal, up, dn, flip, in_seq, err;
  johnson_code_decode #(.NUM_FF(NUM_FF), .IDX_W(IDX_W)) u_dec (
    .jc_in(jc_in),
    .legal(dec_legal),
    .idx(dec_idx)
  );
  assign up = prev_v && dec_idx == IDX_W'(jc_next_idx(5'(prev), NUM_FF));
`ifdef JDEC_BIDIR_EN
  logic dir_q;
  assign dn     = prev_v && dec_idx == IDX_W'(jc_prev_idx(5'(prev), NUM_FF));
  assign flip   = run >= 4'd2 && up != dir_q;
  assign in_seq = dir_q ? up : dn;
  assign dir    = dir_q;
  always_ff @(posedge clk)
    if (rst) dir_q <= 1'b0;
    else if (in_valid && state == HUNT && dec_legal && (up || dn)) dir_q <= up;
`else
  assign dn     = 1'b0;
  assign flip   = 1'b0;
  assign in_seq = up;
`endif
  always_ff @(posedge clk)
    state <= rst ? HUNT : state_n;
  // A step against the run's direction restarts the run at one step
  always_comb begin
    state_n  = state;
    run_n    = run;
    prev_v_n = prev_v;
    err      = 1'b0;
    if (in_valid && state == LOCKED) begin
      err      = !(dec_legal && in_seq);
      state_n  = err ? HUNT : LOCKED;
      run_n    = err ? {3'b000, dec_legal} : run;
      prev_v_n = dec_legal;
    end else if (in_valid) begin
      run_n    = !dec_legal ? 4'd0 : (up || dn) ? (flip ? 4'd2 : run + 4'd1) : 4'd1;
      prev_v_n = dec_legal;
      state_n  = dec_legal && run_n >= 4'(LOCK_CNT) ? LOCKED : HUNT;
    end
  end
  always_ff @(posedge clk)
    if (rst) begin
      run       <= '0;
      prev      <= '0;
      prev_v    <= 1'b0;
      idx_out   <= '0;
      idx_valid <= 1'b0;
      legal     <= 1'b0;
      seq_err   <= 1'b0;
      err_count <= '0;
    end else begin
      run       <= run_n;
      prev_v    <= prev_v_n;
      idx_valid <= in_valid;
      seq_err   <= err;
      if (in_valid) begin
        prev    <= dec_idx;
        idx_out <= dec_idx;
        legal   <= dec_legal;
      end
      if (err && err_count != '1) err_count <= err_count + 1'b1;
    end
  assign locked = state == LOCKED;
endmodule

// File: tb/tb_johnson_decoder_monitor.sv
// tb_johnson_decoder_monitor: directed checks of decode, lock, errors, saturation and wrap
module tb_johnson_decoder_monitor;
  logic clk = 0, rst = 1, in_valid = 0, in_valid3 = 0;
  logic [3:0] jc_in = '0;
  logic [2:0] jc3 = '0;
  logic [2:0] idx_out, idx3;
  logic idx_valid, legal, seq_err, locked, iv3, lg3, se3, lk3;
  logic [7:0] err_count, ec3;
  int tests = 0, fails = 0, p = 0;
`ifdef JDEC_BIDIR_EN
  logic dir, dir3;
`endif
  always #5 clk = ~clk;
  johnson_decoder_monitor #(.NUM_FF(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .jc_in(jc_in),
    .idx_out(idx_out), .idx_valid(idx_valid), .legal(legal),
    .seq_err(seq_err), .locked(locked),
`ifdef JDEC_BIDIR_EN
    .dir(dir),
`endif
    .err_count(err_count)
  );
  johnson_decoder_monitor #(.NUM_FF(3)) dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid3), .jc_in(jc3),
    .idx_out(idx3), .idx_valid(iv3), .legal(lg3),
    .seq_err(se3), .locked(lk3),
`ifdef JDEC_BIDIR_EN
    .dir(dir3),
`endif
    .err_count(ec3)
  );
  function automatic logic [3:0] jc4(input int i);
    return i <= 4 ? 4'(((1 << i) - 1) << (4 - i)) : 4'((1 << (8 - i)) - 1);
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [3:0] c, input logic v);
    jc_in = c;
    in_valid = v;
    tick();
  endtask
  task automatic test_reset;
    rst = 1; in_valid = 1; jc_in = 4'b1000; in_valid3 = 1; jc3 = 3'b100;
    tick(); tick();
    tests++;
    if ({idx_out, idx_valid, legal, seq_err, locked, err_count} !== 15'd0) begin
      fails++; $display("FAIL reset4 got %h want 0", {idx_out, idx_valid, legal, seq_err, locked, err_count});
    end
    tests++;
    if ({idx3, iv3, lg3, se3, lk3, ec3} !== 15'd0) begin
      fails++; $display("FAIL reset3 got %h want 0", {idx3, iv3, lg3, se3, lk3, ec3});
    end
`ifdef JDEC_BIDIR_EN
    tests++;
    if (dir !== 1'b0) begin fails++; $display("FAIL reset_dir got %b want 0", dir); end
`endif
    rst = 0; in_valid = 0; in_valid3 = 0;
  endtask
  task automatic test_sequence;
    logic [3:0] seq [0:8] = '{4'b0000, 4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b0111, 4'b0011, 4'b0001, 4'b0000};
    for (int j = 0; j < 9; j++) begin
      drive(seq[j], 1);
      tests++;
      if (idx_out !== 3'(j % 8) || {idx_valid, legal, seq_err} !== 3'b110) begin
        fails++; $display("FAIL seq[%0d] idx %0d vl_se %b want %0d 110", j, idx_out, {idx_valid, legal, seq_err}, j % 8);
      end
      if (j != 1) begin
        tests++;
        if (locked !== (j >= 2)) begin fails++; $display("FAIL seq_lock[%0d] got %b want %b", j, locked, j >= 2); end
      end
    end
    tests++;
    if (err_count !== 8'd0) begin fails++; $display("FAIL seq_errcnt got %0d want 0", err_count); end
  endtask
  task automatic test_illegal;
    drive(4'b1000, 1); drive(4'b1100, 1);
    drive(4'b1010, 1);
    tests++;
    if ({idx_out, legal, seq_err, locked} !== 6'b000010 || err_count !== 8'd1) begin
      fails++; $display("FAIL illegal idx %0d l/se/lk %b cnt %0d want 0 010 1", idx_out, {legal, seq_err, locked}, err_count);
    end
    drive(4'b1100, 1);
    tests++;
    if (idx_out !== 3'd2 || {legal, seq_err, locked} !== 3'b100) begin
      fails++; $display("FAIL resume1 idx %0d l/se/lk %b want 2 100", idx_out, {legal, seq_err, locked});
    end
    drive(4'b1110, 1);
    tests++;
    if (idx_out !== 3'd3 || {seq_err, locked} !== 2'b01) begin
      fails++; $display("FAIL relock idx %0d se/lk %b want 3 01", idx_out, {seq_err, locked});
    end
  endtask
  task automatic test_skip;
    drive(4'b0111, 1);
    tests++;
    if (idx_out !== 3'd5 || {legal, seq_err, locked} !== 3'b110 || err_count !== 8'd2) begin
      fails++; $display("FAIL skip idx %0d l/se/lk %b cnt %0d want 5 110 2", idx_out, {legal, seq_err, locked}, err_count);
    end
    drive(4'b0011, 1);
    tests++;
    if (idx_out !== 3'd6 || {seq_err, locked} !== 2'b01) begin
      fails++; $display("FAIL skip_relock idx %0d se/lk %b want 6 01", idx_out, {seq_err, locked});
    end
  endtask
  task automatic test_gap;
    for (int j = 0; j < 5; j++) begin
      drive(4'b1010, 0);
      tests++;
      if ({idx_valid, seq_err, locked, legal} !== 4'b0011 || idx_out !== 3'd6) begin
        fails++; $display("FAIL gap[%0d] v/se/lk/l %b idx %0d want 0011 6", j, {idx_valid, seq_err, locked, legal}, idx_out);
      end
    end
    drive(4'b0001, 1);
    tests++;
    if (idx_out !== 3'd7 || {idx_valid, seq_err, locked} !== 3'b101 || err_count !== 8'd2) begin
      fails++; $display("FAIL gap_resume idx %0d v/se/lk %b cnt %0d want 7 101 2", idx_out, {idx_valid, seq_err, locked}, err_count);
    end
  endtask
  task automatic test_saturation;
    int exp;
    p = 7;
    for (int e = 0; e < 300; e++) begin
      exp = (3 + e > 255) ? 255 : 3 + e;
      drive(jc4((p + 2) % 8), 1);
      tests++;
      if (seq_err !== 1'b1 || err_count !== 8'(exp)) begin
        fails++; $display("FAIL sat_err[%0d] se %b cnt %0d want 1 %0d", e, seq_err, err_count, exp);
      end
      drive(jc4((p + 3) % 8), 1);
      p = (p + 3) % 8;
      tests++;
      if (locked !== 1'b1) begin fails++; $display("FAIL sat_lock[%0d] got %b want 1", e, locked); end
    end
    drive(jc4(p), 1);
    tests++;
    if (seq_err !== 1'b1 || locked !== 1'b0 || err_count !== 8'd255) begin
      fails++; $display("FAIL repeat se %b lk %b cnt %0d want 1 0 255", seq_err, locked, err_count);
    end
    drive(jc4((p + 1) % 8), 1);
    p = (p + 1) % 8;
    tests++;
    if (locked !== 1'b1 || err_count !== 8'd255) begin
      fails++; $display("FAIL repeat_relock lk %b cnt %0d want 1 255", locked, err_count);
    end
  endtask
  task automatic test_reset_mid;
    rst = 1;
    drive(jc4((p + 1) % 8), 1);
    tests++;
    if ({idx_out, idx_valid, legal, seq_err, locked, err_count} !== 15'd0) begin
      fails++; $display("FAIL reset_mid got %h want 0", {idx_out, idx_valid, legal, seq_err, locked, err_count});
    end
    rst = 0;
    drive(4'b0000, 0);
  endtask
  task automatic test_wrap3;
    logic [2:0] s3 [0:6] = '{3'b000, 3'b100, 3'b110, 3'b111, 3'b011, 3'b001, 3'b000};
    in_valid3 = 1;
    for (int j = 0; j < 7; j++) begin
      jc3 = s3[j];
      tick();
      tests++;
      if (idx3 !== 3'(j % 6) || {iv3, lg3, se3} !== 3'b110 || ec3 !== 8'd0) begin
        fails++; $display("FAIL wrap3[%0d] idx %0d v/l/se %b cnt %0d want %0d 110 0", j, idx3, {iv3, lg3, se3}, ec3, j % 6);
      end
    end
    tests++;
    if (lk3 !== 1'b1) begin fails++; $display("FAIL wrap3_lock got %b want 1", lk3); end
    in_valid3 = 0;
  endtask
`ifdef JDEC_BIDIR_EN
  task automatic test_bidir;
    drive(4'b0000, 1); drive(4'b0001, 1); drive(4'b0011, 1);
    tests++;
    if ({dir, locked, seq_err} !== 3'b010 || idx_out !== 3'd6) begin
      fails++; $display("FAIL bidir dir/lk/se %b idx %0d want 010 6", {dir, locked, seq_err}, idx_out);
    end
  endtask
`endif
  initial begin
    test_reset();
    test_sequence();
    test_illegal();
    test_skip();
    test_gap();
    test_saturation();
    test_reset_mid();
    test_wrap3();
`ifdef JDEC_BIDIR_EN
    test_bidir();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/johnson_decoder_monitor.md
Name: johnson_decoder_monitor

Overview:
- Receiving end of a Johnson-coded count bus, as produced by the team's Johnson counter: NUM_FF bits, 2*NUM_FF states, reset code all-zero, each step shifts right and inserts the inverted LSB at the MSB.
- Decodes each sampled code to a binary index, checks that the code is legal, and tracks sequence continuity with a HUNT/LOCKED state machine.
- Counts sequence errors; sits beside any Johnson-counted state or timing chain as a health monitor.

Parameters:
- NUM_FF, 4, Johnson code width; legal range 2..16.
- IDX_W, $clog2(2*NUM_FF), width of the decoded index.
- ERR_W, 8, width of the saturating error counter.
- LOCK_CNT, 2, consecutive in-sequence valid samples needed to lock; range 1..15.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  jc_in is sampled this cycle.
- jc_in  in  NUM_FF  Johnson code under test.
- idx_out  out  IDX_W  decoded index, 0..2*NUM_FF-1.
- idx_valid  out  1  registered copy of in_valid.
- legal  out  1  sampled code was a legal Johnson code.
- seq_err  out  1  one-cycle pulse on a continuity or legality error while LOCKED.
- locked  out  1  FSM is in LOCKED.
- err_count  out  ERR_W  number of seq_err pulses, saturating.

Behaviour:
- Reset: idx_out=0, idx_valid=0, legal=0, seq_err=0, locked=0, err_count=0, FSM=HUNT, run counter=0, no previous index.
- Reset wins over in_valid in the same cycle. A reset asserted mid-operation clears all state at that edge.
- Latency: exactly 1 cycle from a sampled input to all outputs.
- When in_valid=0: idx_valid=0 and seq_err=0 next cycle; idx_out, legal, FSM state and run counter hold.
- Legality:
  - A code is legal iff there is at most one position i in 0..NUM_FF-2 where jc_in[i] != jc_in[i+1].
  - Every other code is illegal.
- Decode, with p = popcount(jc_in):
  - If jc_in is zero or its MSB is 1, index = p.
  - Otherwise index = 2*NUM_FF - p.
  - Example for NUM_FF=4: 0000→0, 1000→1, 1111→4, 0111→5, 0001→7.
  - For an illegal code, idx_out is driven to 0 and legal=0.
- In sequence: the current index equals (previous valid index + 1) mod 2*NUM_FF.
  - Use an explicit compare against 2*NUM_FF-1, not bit-width wrap, so NUM_FF=3 wraps 5→0.
- HUNT state:
  - A legal sample that is in sequence, or the first legal sample after reset or after an error, loads or increments the run counter. It stores the index as previous.
  - An illegal sample sets run=0 and clears the previous index.
  - When a legal sample brings run to LOCK_CNT, the FSM moves to LOCKED and locked=1 next cycle.
  - seq_err is never asserted in HUNT.
- LOCKED state:
  - A legal, in-sequence sample stays LOCKED and updates previous.
  - An illegal or out-of-sequence sample pulses seq_err and increments err_count, saturating at all-ones.
  - On that error the FSM goes to HUNT with run=1 and previous=index if the sample was legal, else run=0.
  - A repeated identical index counts as out-of-sequence.
- err_count never wraps and is cleared only by rst.

Optional Feature:
- Macro: JDEC_BIDIR_EN.
- Defined:
  - Adds output port dir (1 bit; 1=up, 0=down), reset 0.
  - The first in-sequence step in HUNT fixes the direction: +1 sets up, −1 (mod 2*NUM_FF) sets down.
  - Locking requires all LOCK_CNT steps in one direction.
  - In LOCKED, a step in the opposite direction is a seq_err.
- Undefined:
  - No dir port; only +1 steps are in sequence; logic is exactly as above.

Decomposition:
- Package johnson_pkg:
  - FSM state typedef {HUNT, LOCKED}.
  - Function jc_legal(code).
  - Function jc_to_idx(code, n).
  - Function jc_next_idx(idx, n) for the mod-2N increment.
- Sub-module johnson_code_decode: combinational legal and index from jc_in. Instantiated once; reusable by other Johnson consumers.

Test Plan:
- NUM_FF=4, rst for 2 cycles, then codes 0000,1000,1100,1110,1111,0111,0011,0001,0000 with in_valid=1 → idx_out 0..7,0 one cycle later; locked=1 from the 3rd output; seq_err never asserted; err_count=0.
- While locked, inject 1010 → legal=0, seq_err pulses once, locked=0, err_count=1. Resume at 1100 then 1110 → relocks after 2 samples.
- While locked at index 3, send 0111 (index 5, skip) → seq_err pulse, err_count+1, HUNT with run=1. Then 0011 → locked.
- in_valid low for 5 cycles mid-sequence, then resume with the next code → no error; idx_valid low during the gap; locked stays 1.
- Force 300 alternating errors with ERR_W=8 → err_count saturates at 255. Assert rst mid-stream → all outputs 0 next cycle.
- NUM_FF=3, sequence ending at 001 (idx 5) followed by 000 → wraps to idx 0 with no error. With JDEC_BIDIR_EN: a descending sequence 0000,0001,0011 → dir=0, locked=1.
